csr_dma: RTL and testbench

- CSR-programmed Wishbone bus master that copies a block of 32-bit words from one system address to another.
- Software programs it over the CSR bus as a CSR slave, the same way it programs uart and sysctl.
- It initiates its own Wishbone cycles on the free conbus master port m2, so its Wishbone side is the initiator end of the bus that csrbrg, bram and the other slaves answer.
- Completion is signalled by a status flag and an optional level interrupt.

---
 rtl/csr_dma.sv | 198 +++++++++++++++++++
 tb/tb_csr_dma.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_dma.sv
// CSR-programmed Wishbone block-copy DMA master (SRC -> DST, LEN words).
// Define CSR_DMA_FILL_EN to add fill mode, which writes a constant pattern instead of copying.
`timescale 1ns/1ps
module csr_dma #(
  parameter logic [3:0] csr_addr  = 4'h2,
  parameter int         len_width = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        irq,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic [2:0]  wb_cti_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t               state;
  logic [31:0]          src;
  logic [31:0]          dst;
  logic [31:0]          buffer;
  logic [len_width-1:0] len;
  logic [len_width-1:0] remain;
  logic                 busy;
  logic                 done;
  logic                 irq_en;
  logic                 aborted;
  logic                 abort_pending;
  logic                 fill;

`ifdef CSR_DMA_FILL_EN
  logic [31:0]          fill_pattern;
`else
  assign fill = 1'b0;
`endif

  logic        page_sel;
  logic        csr_wr;
  logic        ctrl_wr;
  logic        start;
  logic [31:0] stat;
  logic        unused_csr_a;

  assign page_sel     = (csr_a[13:10] == csr_addr);
  assign csr_wr       = page_sel & csr_we;
  assign ctrl_wr      = csr_wr & (csr_a[2:0] == 3'd3);
  assign start        = ctrl_wr & csr_di[0];
  assign stat         = {27'd0, aborted, fill, done, irq_en, busy};
  assign wb_sel_o     = 4'hf;
  assign wb_cti_o     = 3'b000;
  assign unused_csr_a = ^csr_a[9:3];

  // Each bus access first spends a cycle with cyc low, then holds cyc/stb until ack.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      src           <= '0;
      dst           <= '0;
      len           <= '0;
      remain        <= '0;
      buffer        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      irq_en        <= 1'b0;
      aborted       <= 1'b0;
      abort_pending <= 1'b0;
      csr_do        <= '0;
      irq           <= 1'b0;
      wb_adr_o      <= '0;
      wb_dat_o      <= '0;
      wb_we_o       <= 1'b0;
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
`ifdef CSR_DMA_FILL_EN
      fill          <= 1'b0;
      fill_pattern  <= '0;
`endif
    end else begin
      csr_do <= '0;
      if (page_sel && !csr_we) begin
        case (csr_a[2:0])
          3'd0:    csr_do <= src;
          3'd1:    csr_do <= dst;
          3'd2:    csr_do <= 32'(len);
          3'd3:    csr_do <= stat;
          3'd4:    csr_do <= 32'(remain);
          default: csr_do <= '0;
        endcase
      end

      irq <= done & irq_en;

      if (csr_wr && !busy) begin
        case (csr_a[2:0])
          3'd0: begin
            src <= {csr_di[31:2], 2'b00};
`ifdef CSR_DMA_FILL_EN
            fill_pattern <= csr_di;
`endif
          end
          3'd1:    dst <= {csr_di[31:2], 2'b00};
          3'd2:    len <= csr_di[len_width-1:0];
          default: ;
        endcase
      end

      if (ctrl_wr) begin
        irq_en <= csr_di[1];
        if (csr_di[2])
          done <= 1'b0;
        if (csr_di[3] && busy)
          abort_pending <= 1'b1;
      end

      // Later assignments here deliberately override the CTRL side effects above.
      unique case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              remain        <= len;
              done          <= 1'b0;
              aborted       <= 1'b0;
              abort_pending <= 1'b0;
              busy          <= 1'b1;
`ifdef CSR_DMA_FILL_EN
              fill   <= csr_di[4];
              buffer <= fill_pattern;
              state  <= csr_di[4] ? WRITE : READ;
`else
              state  <= READ;
`endif
            end else begin
              done <= 1'b1;
            end
          end
        end
        READ: begin
          if (!wb_cyc_o) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b0;
            wb_adr_o <= src;
          end else if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            buffer   <= wb_dat_i;
            src      <= src + 32'd4;
            if (abort_pending) begin
              state         <= IDLE;
              busy          <= 1'b0;
              done          <= 1'b1;
              aborted       <= 1'b1;
              abort_pending <= 1'b0;
            end else begin
              state <= WRITE;
            end
          end
        end
        WRITE: begin
          if (!wb_cyc_o) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b1;
            wb_adr_o <= dst;
            wb_dat_o <= buffer;
          end else if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            dst      <= dst + 32'd4;
            remain   <= remain - len_width'(1);
            if (remain == len_width'(1) || abort_pending) begin
              state         <= IDLE;
              busy          <= 1'b0;
              done          <= 1'b1;
              aborted       <= abort_pending;
              abort_pending <= 1'b0;
            end else begin
              state <= fill ? WRITE : READ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_dma.sv
// Scoreboard bench for csr_dma: a word-level transfer model predicts bus cycles and CSR reads.
`timescale 1ns/1ps
module tb_csr_dma;

  localparam logic [3:0] PAGE = 4'h2;
`ifdef CSR_DMA_FILL_EN
  localparam bit FILL_BUILD = 1'b1;
`else
  localparam bit FILL_BUILD = 1'b0;
`endif

  logic        sys_clk;
  logic        sys_rst_n;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic        irq;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic [2:0]  wb_cti_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;

  csr_dma #(.csr_addr(PAGE), .len_width(16)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di), .csr_do(csr_do), .irq(irq),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cti_o(wb_cti_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Slave memory: 1024 words aliased by address bits [11:2], ack after wait_states cycles.
  logic [31:0] mem [0:1023];
  int wait_states = 0;
  int ws_cnt = 0;
  assign wb_dat_i = mem[wb_adr_o[11:2]];
  assign wb_ack_i = wb_cyc_o && wb_stb_o && (ws_cnt >= wait_states);

  always @(posedge sys_clk) begin
    if (wb_cyc_o && wb_stb_o && !wb_ack_i) ws_cnt <= ws_cnt + 1;
    else ws_cnt <= 0;
  end

  function automatic logic [31:0] pattern(input int i);
    return 32'hC0DE0000 ^ (32'(i) * 32'h00010203);
  endfunction

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    int          gap;
    bit          last;
    bit          irq;
  } bus_exp_t;

  typedef struct {
    string       name;
    logic [31:0] val;
    bit          chk_irq;
    bit          irq;
  } csr_exp_t;

  bus_exp_t exp_q[$];
  csr_exp_t csr_q[$];
  logic [31:0] model_mem [0:1023];

  int vectors = 0;
  int miscompares = 0;
  int timeouts = 0;
  bit rd_req = 1'b0;

  // Monitor state
  bit          prev_rst = 1'b0;
  bit          prev_ack = 1'b0;
  bit          prev_wait = 1'b0;
  bit          prev_we = 1'b0;
  logic [31:0] prev_adr = '0;
  bit          rd_pend = 1'b0;
  int          cycle = 0;
  int          last_ack = 0;
  int          irq_watch = 0;
  int          timeouts_seen = 0;
  bus_exp_t    e;
  csr_exp_t    c;
  bit          ok;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = pattern(i);
    forever begin
      @(negedge sys_clk);
      cycle++;
      if (!sys_rst_n) begin
        if (prev_rst) begin
          vectors++;
          if ({wb_cyc_o, wb_stb_o, wb_we_o} != 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_drop: cyc/stb/we=%b, want 000", {wb_cyc_o, wb_stb_o, wb_we_o});
          end
        end
        prev_ack = 1'b0;
        prev_wait = 1'b0;
        irq_watch = 0;
      end else begin
        if (irq_watch == 2) begin
          vectors++;
          if (irq !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL irq_rise: irq=%b, want 1", irq);
          end
          irq_watch = 0;
        end else if (irq_watch == 1) begin
          vectors++;
          if (irq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL irq_lag: irq=%b, want 0", irq);
          end
          irq_watch = 2;
        end
        if (prev_ack) begin
          vectors++;
          if (wb_cyc_o || wb_stb_o) begin
            miscompares++;
            $display("[TB] FAIL bus_gap: cyc=%b stb=%b after ack, want 0 0", wb_cyc_o, wb_stb_o);
          end
        end
        if (prev_wait) begin
          vectors++;
          if (!(wb_cyc_o && wb_stb_o && wb_adr_o == prev_adr && wb_we_o == prev_we)) begin
            miscompares++;
            $display("[TB] FAIL bus_hold: cyc=%b adr=%h we=%b, want 1 %h %b",
                     wb_cyc_o, wb_adr_o, wb_we_o, prev_adr, prev_we);
          end
        end
        if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_cycle: we=%b adr=%h, want no bus cycle", wb_we_o, wb_adr_o);
          end else begin
            e = exp_q.pop_front();
            ok = (wb_we_o == e.we) && (wb_adr_o == e.adr) && (!e.we || wb_dat_o == e.dat) &&
                 (wb_sel_o == 4'hf) && (wb_cti_o == 3'b000) && (e.gap == 0 || cycle - last_ack == e.gap);
            if (!ok) begin
              miscompares++;
              $display("[TB] FAIL bus_seq: got we=%b adr=%h dat=%h sel=%h cti=%0d gap=%0d, want we=%b adr=%h dat=%h gap=%0d",
                       wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, cycle - last_ack,
                       e.we, e.adr, e.dat, e.gap);
            end
            if (e.last && e.irq) irq_watch = 1;
          end
          if (wb_we_o) mem[wb_adr_o[11:2]] = wb_dat_o;
          last_ack = cycle;
        end
        prev_ack = wb_cyc_o && wb_stb_o && wb_ack_i;
        prev_wait = wb_cyc_o && wb_stb_o && !wb_ack_i;
        prev_adr = wb_adr_o;
        prev_we = wb_we_o;
      end
      prev_rst = sys_rst_n;
      if (rd_pend) begin
        vectors++;
        if (csr_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL csr_queue: read data %h with no expectation", csr_do);
        end else begin
          c = csr_q.pop_front();
          if (csr_do !== c.val || (c.chk_irq && irq !== c.irq)) begin
            miscompares++;
            $display("[TB] FAIL %s: got csr_do=%h irq=%b, want %h irq=%b", c.name, csr_do, irq, c.val, c.irq);
          end
        end
      end
      rd_pend = rd_req;
      if (timeouts != timeouts_seen) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL timeout: DUT did not reach expected bus event, count=%0d want 0", timeouts);
        timeouts_seen = timeouts;
      end
    end
  end

  function automatic logic [13:0] reg_a(input logic [2:0] idx);
    return {PAGE, 7'd0, idx};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic csr_write(input logic [2:0] idx, input logic [31:0] d);
    csr_a = reg_a(idx);
    csr_di = d;
    csr_we = 1'b1;
    tick();
    csr_we = 1'b0;
    csr_di = '0;
  endtask

  task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d, input int n);
    csr_write(3'd0, s);
    csr_write(3'd1, d);
    csr_write(3'd2, 32'(n));
  endtask

  task automatic checkOutput(input string name, input logic [13:0] a, input logic [31:0] v,
                             input bit chk_irq, input bit exp_irq);
    csr_q.push_back('{name, v, chk_irq, exp_irq});
    csr_a = a;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  // Reference model: a transfer is LEN iterations of "read word, write word" (or write pattern in fill mode).
  task automatic push_transfer(input logic [31:0] s, input logic [31:0] d, input int n, input int ws,
                               input bit fill, input bit irq_on, input int stop_reads, input bit update);
    logic [31:0] sa, da, data;
    int gap;
    sa = {s[31:2], 2'b00};
    da = {d[31:2], 2'b00};
    gap = 0;
    for (int i = 0; i < n; i++) begin
      if (!fill) begin
        exp_q.push_back('{1'b0, sa + 32'(4 * i), 32'h0, gap, 1'b0, 1'b0});
        gap = 2 + ws;
      end
      data = fill ? s : model_mem[(sa + 32'(4 * i)) >> 2 & 32'h3ff];
      if (stop_reads == i + 1) break;
      exp_q.push_back('{1'b1, da + 32'(4 * i), data, gap, 1'b0, 1'b0});
      gap = 2 + ws;
      if (update) model_mem[(da + 32'(4 * i)) >> 2 & 32'h3ff] = data;
    end
    exp_q[exp_q.size() - 1].last = 1'b1;
    exp_q[exp_q.size() - 1].irq = irq_on;
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      timeouts++;
      exp_q.delete();
    end
    repeat (3) tick();
  endtask

  int n;
  logic [31:0] rs, rd;
  int rl, rw;
  bit ri;

  initial begin
    sys_rst_n = 1'b0;
    csr_a = '0;
    csr_we = 1'b0;
    csr_di = '0;
    for (int i = 0; i < 1024; i++) model_mem[i] = pattern(i);
    repeat (3) tick();
    sys_rst_n = 1'b1;
    tick();
    $display("[TB] reset state");
    checkOutput("reset_stat", reg_a(3'd3), 32'h0, 1'b1, 1'b0);
    checkOutput("reset_src", reg_a(3'd0), 32'h0, 1'b0, 1'b0);

    $display("[TB] reset during WRITE");
    wait_states = 5;
    applyStimulus(32'h180, 32'h280, 1);
    push_transfer(32'h180, 32'h280, 1, 5, 1'b0, 1'b0, 0, 1'b0);
    csr_write(3'd3, 32'h1);
    n = 0;
    while (!(wb_cyc_o && wb_we_o) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) timeouts++;
    sys_rst_n = 1'b0;
    exp_q.delete();
    tick();
    tick();
    sys_rst_n = 1'b1;
    wait_states = 0;
    tick();
    checkOutput("post_reset_stat", reg_a(3'd3), 32'h0, 1'b1, 1'b0);
    checkOutput("post_reset_remain", reg_a(3'd4), 32'h0, 1'b0, 1'b0);
    checkOutput("post_reset_dst", reg_a(3'd1), 32'h0, 1'b0, 1'b0);
    checkOutput("unused_index", reg_a(3'd7), 32'h0, 1'b0, 1'b0);

    $display("[TB] zero-wait copy of 3 words");
    applyStimulus(32'h100, 32'h200, 3);
    push_transfer(32'h100, 32'h200, 3, 0, 1'b0, 1'b0, 0, 1'b1);
    csr_write(3'd3, 32'h1);
    wait_drain(200);
    checkOutput("copy_stat", reg_a(3'd3), 32'h4, 1'b1, 1'b0);
    checkOutput("copy_remain", reg_a(3'd4), 32'h0, 1'b0, 1'b0);
    checkOutput("copy_src", reg_a(3'd0), 32'h10c, 1'b0, 1'b0);
    checkOutput("copy_dst", reg_a(3'd1), 32'h20c, 1'b0, 1'b0);
    checkOutput("other_page", {4'h5, 7'd0, 3'd0}, 32'h0, 1'b0, 1'b0);

    $display("[TB] wait-state copy with irq");
    wait_states = 5;
    applyStimulus(32'h100, 32'h200, 3);
    push_transfer(32'h100, 32'h200, 3, 5, 1'b0, 1'b1, 0, 1'b1);
    csr_write(3'd3, 32'h3);
    wait_drain(400);
    checkOutput("irq_stat", reg_a(3'd3), 32'h6, 1'b1, 1'b1);
    csr_write(3'd3, 32'h4);
    checkOutput("irq_clear", reg_a(3'd3), 32'h0, 1'b1, 1'b0);

    $display("[TB] zero-length start");
    wait_states = 0;
    csr_write(3'd2, 32'h0);
    csr_write(3'd3, 32'h1);
    repeat (4) tick();
    checkOutput("len0_stat", reg_a(3'd3), 32'h4, 1'b0, 1'b0);

    $display("[TB] writes while busy");
    wait_states = 3;
    applyStimulus(32'h400, 32'h600, 4);
    push_transfer(32'h400, 32'h600, 4, 3, 1'b0, 1'b0, 0, 1'b1);
    csr_write(3'd3, 32'h1);
    tick();
    csr_write(3'd0, 32'h800);
    csr_write(3'd2, 32'h7);
    csr_write(3'd1, 32'h900);
    csr_write(3'd3, 32'h1);
    wait_drain(400);
    checkOutput("busy_stat", reg_a(3'd3), 32'h4, 1'b0, 1'b0);
    checkOutput("busy_len", reg_a(3'd2), 32'h4, 1'b0, 1'b0);
    checkOutput("busy_src", reg_a(3'd0), 32'h410, 1'b0, 1'b0);
    checkOutput("busy_dst", reg_a(3'd1), 32'h610, 1'b0, 1'b0);

    $display("[TB] start+clear priority, abort in second read");
    applyStimulus(32'h500, 32'h700, 5);
    push_transfer(32'h500, 32'h700, 5, 3, 1'b0, 1'b0, 2, 1'b1);
    csr_write(3'd3, 32'h5);
    checkOutput("start_clear_stat", reg_a(3'd3), 32'h1, 1'b0, 1'b0);
    n = 0;
    while (!(wb_cyc_o && wb_we_o) && n < 100) begin
      tick();
      n++;
    end
    while (!(wb_cyc_o && !wb_we_o) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) timeouts++;
    csr_write(3'd3, 32'h8);
    wait_drain(200);
    checkOutput("abort_stat", reg_a(3'd3), 32'h14, 1'b0, 1'b0);
    checkOutput("abort_remain", reg_a(3'd4), 32'h4, 1'b0, 1'b0);
    csr_write(3'd3, 32'h8);
    repeat (3) tick();
    checkOutput("idle_abort_stat", reg_a(3'd3), 32'h14, 1'b0, 1'b0);

    $display("[TB] fill request (copy when fill is not built)");
    wait_states = 0;
    applyStimulus(32'hDEADBEEF, 32'h300, 2);
    push_transfer(32'hDEADBEEF, 32'h300, 2, 0, FILL_BUILD, 1'b0, 0, 1'b1);
    csr_write(3'd3, 32'h11);
    wait_drain(200);
    checkOutput("fill_stat", reg_a(3'd3), FILL_BUILD ? 32'hc : 32'h4, 1'b0, 1'b0);
    checkOutput("fill_src", reg_a(3'd0), FILL_BUILD ? 32'hDEADBEEC : 32'hDEADBEF4, 1'b0, 1'b0);

    $display("[TB] random transfers");
    for (int t = 0; t < 8; t++) begin
      rs = 32'($urandom_range(0, 1023)) << 2;
      rd = 32'($urandom_range(0, 1023)) << 2;
      rl = int'($urandom_range(1, 8));
      rw = int'($urandom_range(0, 3));
      ri = 1'($urandom_range(0, 1));
      wait_states = rw;
      applyStimulus(rs, rd, rl);
      push_transfer(rs, rd, rl, rw, 1'b0, ri, 0, 1'b1);
      csr_write(3'd3, {30'd0, ri, 1'b1});
      wait_drain(400);
      checkOutput("rand_stat", reg_a(3'd3), {29'd0, 1'b1, ri, 1'b0}, 1'b1, ri);
      checkOutput("rand_remain", reg_a(3'd4), 32'h0, 1'b0, 1'b0);
      checkOutput("rand_src", reg_a(3'd0), rs + 32'(4 * rl), 1'b0, 1'b0);
      checkOutput("rand_dst", reg_a(3'd1), rd + 32'(4 * rl), 1'b0, 1'b0);
    end

    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
